// File: rtl/mips_mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : MIPS_Generic_Definitions (package)
//  Description : Shared MIPS datapath types and constants: operand width,
//                ALU select codes, multiply/divide unit opcodes and the
//                multiply/divide unit sequencer states.
//  Revision    : 1.0 - initial release
// ============================================================================
package MIPS_Generic_Definitions;

    // Architectural operand width.
    localparam int Data_Width     = 32;

    // Multiply/divide unit performs one bit per iteration.
    localparam int MDU_ITERATIONS = Data_Width;

    // ALU function select.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_sel_t;

    // Multiply/divide unit operation.
    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_t;

    // Multiply/divide unit sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_t;

    // True for the operations that interpret operands as two's complement.
    function automatic logic mdu_is_signed(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_mdu_signfix.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mdu_signfix
//  Description : Conditional two's-complement negate. Used both to take the
//                magnitude of a signed operand and to restore the sign of a
//                result.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_mdu_signfix
    import MIPS_Generic_Definitions::*;
#(
    parameter int WIDTH = Data_Width
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    // Negate when requested, otherwise pass through unchanged.
    always_comb begin
        o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;
    end

endmodule
`default_nettype wire

// File: rtl/mips_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mdu
//  Description : MIPS multiply/divide unit with HI/LO registers. Iterative
//                shift-add multiply and restoring divide on unsigned
//                magnitudes, one bit per clock, followed by a sign-fix cycle.
//                Fixed latency: result written Data_Width+1 edges after the
//                accepting edge.
//                Build option: define MIPS_MDU_DIV_EN to include the divide
//                datapath; otherwise DIV/DIVU complete in one cycle with no
//                effect on HI/LO.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_mdu
    import MIPS_Generic_Definitions::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  mdu_op_t               mdu_op,
    input  logic [Data_Width-1:0] data_in1,
    input  logic [Data_Width-1:0] data_in2,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero,
    output logic [Data_Width-1:0] hi,
    output logic [Data_Width-1:0] lo
);

    localparam int                 c_W     = Data_Width;
    localparam int                 c_CNT_W = $clog2(MDU_ITERATIONS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(MDU_ITERATIONS - 1);

    mdu_state_t         r_state;
    mdu_state_t         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_W-1:0]     r_acc_hi;   // partial product high / partial remainder
    logic [c_W-1:0]     r_acc_lo;   // multiplier bits / dividend->quotient bits
    logic [c_W-1:0]     r_opnd;     // multiplicand or divisor magnitude
    logic [c_W-1:0]     r_hi;
    logic [c_W-1:0]     r_lo;
    logic               r_neg_lo;   // negate product / quotient in FIX
    logic               r_skip;     // operation completes without a result write
    logic               r_done;
    logic               r_div_zero;

    logic               w_is_arith;
    logic               w_is_div;
    logic               w_signed;
    logic               w_skip_run;
    logic [c_W-1:0]     w_abs1;
    logic [c_W-1:0]     w_abs2;
    logic [c_W:0]       w_mul_sum;
    logic [c_W-1:0]     w_step_hi;
    logic [c_W-1:0]     w_step_lo;
    logic [2*c_W-1:0]   w_prod_fix;

`ifdef MIPS_MDU_DIV_EN
    logic               r_is_div;
    logic               r_neg_hi;   // remainder takes the dividend's sign
    logic [c_W:0]       w_div_shift;
    logic [c_W-1:0]     w_div_sub;
    logic               w_div_ge;
    logic [c_W-1:0]     w_quo_fix;
    logic [c_W-1:0]     w_rem_fix;
`endif

    assign w_is_arith = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU) ||
                        (mdu_op == MDU_DIV)  || (mdu_op == MDU_DIVU);
    assign w_is_div   = (mdu_op == MDU_DIV)  || (mdu_op == MDU_DIVU);
    assign w_signed   = mdu_is_signed(mdu_op);

`ifdef MIPS_MDU_DIV_EN
    // A zero divisor produces no result, so there is nothing to iterate.
    assign w_skip_run = w_is_div && (data_in2 == '0);
`else
    // Without a divider every divide is a one-cycle no-op.
    assign w_skip_run = w_is_div;
`endif

    // Operand magnitudes for the unsigned iterative core.
    mips_mdu_signfix #(.WIDTH(c_W)) u_abs1 (
        .i_val (data_in1),
        .i_neg (w_signed & data_in1[c_W-1]),
        .o_val (w_abs1)
    );

    mips_mdu_signfix #(.WIDTH(c_W)) u_abs2 (
        .i_val (data_in2),
        .i_neg (w_signed & data_in2[c_W-1]),
        .o_val (w_abs2)
    );

    // Sign restoration of the full-width product.
    mips_mdu_signfix #(.WIDTH(2*c_W)) u_prod_fix (
        .i_val ({r_acc_hi, r_acc_lo}),
        .i_neg (r_neg_lo),
        .o_val (w_prod_fix)
    );

`ifdef MIPS_MDU_DIV_EN
    // Sign restoration of quotient and remainder.
    mips_mdu_signfix #(.WIDTH(c_W)) u_quo_fix (
        .i_val (r_acc_lo),
        .i_neg (r_neg_lo),
        .o_val (w_quo_fix)
    );

    mips_mdu_signfix #(.WIDTH(c_W)) u_rem_fix (
        .i_val (r_acc_hi),
        .i_neg (r_neg_hi),
        .o_val (w_rem_fix)
    );
`endif

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
        w_step_hi = w_mul_sum[c_W:1];
        w_step_lo = {w_mul_sum[0], r_acc_lo[c_W-1:1]};
`ifdef MIPS_MDU_DIV_EN
        w_div_shift = {r_acc_hi, r_acc_lo[c_W-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
        // Modulo-width subtract is exact whenever the trial succeeds.
        w_div_sub   = w_div_shift[c_W-1:0] - r_opnd;
        if (r_is_div) begin
            w_step_hi = w_div_ge ? w_div_sub : w_div_shift[c_W-1:0];
            w_step_lo = {r_acc_lo[c_W-2:0], w_div_ge};
        end
`endif
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state: start is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && w_is_arith) begin
                    w_state_nxt = w_skip_run ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, iteration, result write-back and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_opnd     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_neg_lo   <= 1'b0;
            r_skip     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
`ifdef MIPS_MDU_DIV_EN
            r_is_div   <= 1'b0;
            r_neg_hi   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (mdu_op)
                            MDU_MTHI: begin
                                r_div_zero <= 1'b0;
                                r_hi       <= data_in1;
                            end
                            MDU_MTLO: begin
                                r_div_zero <= 1'b0;
                                r_lo       <= data_in1;
                            end
                            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                                r_div_zero <= 1'b0;
                                r_cnt      <= '0;
                                r_skip     <= w_skip_run;
                                r_acc_hi   <= '0;
                                r_acc_lo   <= w_abs1;
                                r_opnd     <= w_abs2;
                                r_neg_lo   <= w_signed & (data_in1[c_W-1] ^ data_in2[c_W-1]);
`ifdef MIPS_MDU_DIV_EN
                                r_is_div   <= w_is_div;
                                r_neg_hi   <= w_signed & data_in1[c_W-1];
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                end
                S_FIX: begin
                    r_done <= 1'b1;
`ifdef MIPS_MDU_DIV_EN
                    if (r_skip) begin
                        r_div_zero <= 1'b1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*c_W-1:c_W];
                        r_lo <= w_prod_fix[c_W-1:0];
                    end
`else
                    if (!r_skip) begin
                        r_hi <= w_prod_fix[2*c_W-1:c_W];
                        r_lo <= w_prod_fix[c_W-1:0];
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire
